mips_imem_loader: RTL and testbench
===================================

// Module: mips_imem_loader
// PURPOSE
//  Writer side of the instruction path: accepts symbolic instruction requests over a valid/ready
//  stream, packs each into a 32-bit MIPS word (R-type, lw, sw, beq, nop) and writes it to
//  sequential instruction-memory addresses. Sits between the testbench/boot source and the imem
//  whose opcode field feeds the main decoder.
// PARAMETERS
//  ADDR_W   6   imem word-address width; capacity = 2**ADDR_W words
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       pulse: begin a program at address 0
//  finish       in   1       pulse: end the program
//  in_valid     in   1       request valid
//  in_ready     out  1       loader can accept a request
//  in_op        in   3       0=RTYPE 1=LW 2=SW 3=BEQ 4=NOP 5..7 illegal
//  in_rs/in_rt/in_rd in 5    register fields
//  in_funct     in   6       R-type funct
//  in_imm       in   16      lw/sw offset, beq word offset
//  imem_we      out  1       imem write strobe
//  imem_addr    out  ADDR_W  imem write address
//  imem_wdata   out  32      packed instruction word
//  count        out  ADDR_W+1 words written in current program
//  full         out  1       capacity reached
//  err          out  1       sticky illegal-op flag (only with ILLEGAL_OP_TRAP_EN)
// BEHAVIOUR
//  Reset: state IDLE; in_ready, imem_we, full, err = 0; imem_addr, imem_wdata, count = 0.
//  FSM IDLE -> LOAD on start (addr, count, full, err cleared). LOAD -> IDLE on finish.
//   LOAD -> FULL after the write to address 2**ADDR_W-1. FULL -> IDLE on finish; FULL -> LOAD on start.
//  in_ready = 1 only in LOAD. Handshake: transfer when in_valid & in_ready.
//  Latency 1: the accepted word appears next cycle with imem_we=1 for exactly one cycle at the current
//   address; address and count increment in that same cycle. No write in any cycle without a transfer.
//  Packing: RTYPE {6'h00,rs,rt,rd,5'b0,funct}; LW {6'h23,rs,rt,imm}; SW {6'h2B,rs,rt,imm};
//   BEQ {6'h04,rs,rt,imm}; NOP 32'h0000_0000. Unused request fields ignored.
//  start in LOAD/FULL restarts at address 0 (a transfer in that same cycle is discarded).
//  start and finish together: start wins. finish with a transfer in the same cycle: word is written,
//   then IDLE. full stays 1 until start/reset; imem_addr holds the last written address when not writing.
//  Reset mid-program: immediate return to reset values; a pending write is dropped.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined: in_op 5..7 is accepted but not written (no imem_we, no increment);
//   err is set and stays 1 until start/reset.
//  Not defined: in_op 5..7 is packed as NOP and written normally; err is tied to 0.
// STRUCTURE
//  mips_pkg: opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04; request
//   op enum (REQ_RTYPE..REQ_NOP); FSM state typedef (IDLE, LOAD, FULL).
//  Sub-module mips_word_pack: combinational request->32-bit word packer (plus illegal flag);
//   the loader owns the FSM, handshake, address counter and write register.
// TESTING
//  1 reset, start, RTYPE rs=1 rt=2 rd=3 funct=6'h20 -> next cycle we=1 addr=0 wdata=32'h0022_1820.
//  2 LW rs=0 rt=8 imm=4, then SW same, then BEQ rs=8 rt=9 imm=16'hFFFF -> addr 0,1,2 with
//    32'h8C08_0004, 32'hAC08_0004, 32'h1109_FFFF; count=3.
//  3 ADDR_W=2, 5 back-to-back NOPs -> 4 writes, full=1 and in_ready=0 after the 4th; 5th not accepted.
//  4 start asserted mid-stream with in_valid=1 -> that request dropped, next write at addr 0, count=1.
//  5 in_op=6: without macro -> wdata=0 written; with ILLEGAL_OP_TRAP_EN -> no write, err=1 until start.
//  6 reset asserted the cycle after a transfer -> no imem_we, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/mips_imem_loader_pkg.sv
// Shared constants and types for the MIPS instruction-memory loader slice.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [2:0] {
    REQ_RTYPE = 3'd0,
    REQ_LW    = 3'd1,
    REQ_SW    = 3'd2,
    REQ_BEQ   = 3'd3,
    REQ_NOP   = 3'd4
  } req_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/mips_imem_loader_if.sv
// Request stream and imem write bus between a boot source and the loader.
interface mips_imem_loader_if #(parameter int unsigned ADDR_W = 6);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_imem_loader_word_pack.sv
// Combinational packer: symbolic request -> 32-bit MIPS word, plus illegal-op flag.
module mips_word_pack
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      REQ_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
      REQ_LW:    word = {OP_LW, rs, rt, imm};
      REQ_SW:    word = {OP_SW, rs, rt, imm};
      REQ_BEQ:   word = {OP_BEQ, rs, rt, imm};
      REQ_NOP:   word = '0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_imem_loader.sv
// Instruction-memory loader: FSM, handshake, address counter and write register.
// Optional ILLEGAL_OP_TRAP_EN: illegal ops are swallowed and raise sticky err.
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  mips_imem_loader_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  state_e            state, state_nx;
  logic              xfer;
  logic              wr_en;
  logic              last;
  logic              pack_illegal;
  logic [31:0]       pack_word;
  logic [ADDR_W-1:0] ptr;

  mips_word_pack u_pack (
    .op      (bus.in_op),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .funct   (bus.in_funct),
    .imm     (bus.in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign bus.in_ready = (state == LOAD);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign last         = (ptr == '1);
`ifdef ILLEGAL_OP_TRAP_EN
  assign wr_en        = xfer & ~pack_illegal;
`else
  assign wr_en        = xfer;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (start)              state_nx = LOAD;
        else if (finish)        state_nx = IDLE;
        else if (wr_en && last) state_nx = FULL;
      end
      FULL: begin
        if (start)       state_nx = LOAD;
        else if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // start takes priority over any same-cycle transfer, so the request is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      count          <= '0;
      full           <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start) begin
        ptr           <= '0;
        bus.imem_addr <= '0;
        count         <= '0;
        full          <= 1'b0;
      end else if (wr_en) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= ptr;
        bus.imem_wdata <= pack_illegal ? '0 : pack_word;
        ptr            <= ptr + ADDR_W'(1);
        count          <= count + (ADDR_W+1)'(1);
        if (last) full <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                     err <= 1'b0;
    else if (start)                err <= 1'b0;
    else if (xfer && pack_illegal) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mips_imem_loader.sv
// Scoreboard bench for mips_imem_loader: directed cases plus random traffic vs a behavioural model.
module tb_mips_imem_loader;

  localparam int unsigned AW  = 2;
  localparam int unsigned CAP = 1 << AW;

  logic        clk = 1'b0;
  logic        reset, start, finish;
  logic [AW:0] count;
  logic        full, err;

  mips_imem_loader_if #(.ADDR_W(AW)) bus ();

  mips_imem_loader #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .finish (finish),
    .bus    (bus),
    .count  (count),
    .full   (full),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [31:0] word;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  bit          m_load   = 1'b0;
  bit          m_full   = 1'b0;
  bit          m_err    = 1'b0;
  int unsigned m_count  = 0;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned op, rs, rt, rd, funct, imm);
    longint unsigned v;
    case (op)
      0: v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + funct;
      1: v = 64'h23 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      2: v = 64'h2B * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      3: v = 64'h04 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle at negedge.
  task automatic step(input bit r, s, f, v, input int unsigned op = 4, rs = 0, rt = 0,
                      rd = 0, funct = 0, imm = 0);
    wr_t w;
    reset        = r;
    start        = s;
    finish       = f;
    bus.in_valid = v;
    bus.in_op    = 3'(op);
    bus.in_rs    = 5'(rs);
    bus.in_rt    = 5'(rt);
    bus.in_rd    = 5'(rd);
    bus.in_funct = 6'(funct);
    bus.in_imm   = 16'(imm);
    @(posedge clk);
    if (r) begin
      m_load = 0; m_full = 0; m_err = 0; m_count = 0;
    end else if (s) begin
      m_load = 1; m_full = 0; m_err = 0; m_count = 0;
    end else if (m_load) begin
      if (v) begin
        if (op > 4 && TRAP) m_err = 1;
        else begin
          w.addr = m_count;
          w.word = ref_word(op, rs, rt, rd, funct, imm);
          exp_q.push_back(w);
          m_count++;
          if (m_count == CAP) begin
            m_load = 0;
            m_full = 1;
          end
        end
      end
      if (f) m_load = 0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_load));
      chk("full", 32'(full), 32'(m_full));
      chk("count", 32'(count), m_count);
      chk("err", 32'(err), 32'(m_err));
      if (bus.imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", 32'(bus.imem_addr), e.addr);
          chk("imem_wdata", bus.imem_wdata, e.word);
        end
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_write: got no write expected addr %0d data %h",
                 exp_q[0].addr, exp_q[0].word);
        exp_q.delete();
      end
    end
  end

  initial begin
    reset = 1; start = 0; finish = 0;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rs = 0; bus.in_rt = 0;
    bus.in_rd = 0; bus.in_funct = 0; bus.in_imm = 0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_we", 32'(bus.imem_we), 0);
    chk("reset_addr", 32'(bus.imem_addr), 0);
    chk("reset_wdata", bus.imem_wdata, 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_ready", 32'(bus.in_ready), 0);
    mon_en = 1'b1;

    // RTYPE packing
    step(0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 2, 3, 6'h20, 0);
    chk("t1_we", 32'(bus.imem_we), 1);
    chk("t1_wdata", bus.imem_wdata, 32'h0022_1820);

    // LW / SW / BEQ
    step(0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 8, 0, 0, 4);
    chk("t2_lw", bus.imem_wdata, 32'h8C08_0004);
    step(0, 0, 0, 1, 2, 0, 8, 0, 0, 4);
    chk("t2_sw", bus.imem_wdata, 32'hAC08_0004);
    step(0, 0, 0, 1, 3, 8, 9, 0, 0, 16'hFFFF);
    chk("t2_beq", bus.imem_wdata, 32'h1109_FFFF);
    chk("t2_addr", 32'(bus.imem_addr), 2);
    chk("t2_count", 32'(count), 3);
    step(0, 0, 1, 0);

    // capacity: five NOPs, the fifth is refused
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 4);
    chk("t3_full", 32'(full), 1);
    chk("t3_ready", 32'(bus.in_ready), 0);
    chk("t3_count", 32'(count), CAP);

    // restart mid-stream drops the same-cycle request
    step(0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0, 2, 2, 2, 2, 0);
    step(0, 1, 0, 1, 0, 3, 3, 3, 3, 0);
    step(0, 0, 0, 1, 1, 4, 5, 0, 0, 7);
    chk("t4_addr", 32'(bus.imem_addr), 0);
    chk("t4_count", 32'(count), 1);
    chk("t4_wdata", bus.imem_wdata, 32'h8C85_0007);

    // illegal op
    step(0, 1, 0, 0);
    step(0, 0, 0, 1, 6, 31, 31, 31, 63, 16'hFFFF);
    chk("t5_we", 32'(bus.imem_we), TRAP ? 0 : 1);
    chk("t5_err", 32'(err), TRAP ? 1 : 0);
    step(0, 0, 0, 0);
    chk("t5_err_hold", 32'(err), TRAP ? 1 : 0);
    step(0, 1, 0, 0);
    chk("t5_err_clr", 32'(err), 0);

    // reset right after a transfer, and reset dropping a same-cycle transfer
    step(0, 0, 0, 1, 3, 1, 2, 0, 0, 5);
    step(1, 0, 0, 1, 3, 1, 2, 0, 0, 6);
    chk("t6_we", 32'(bus.imem_we), 0);
    chk("t6_addr", 32'(bus.imem_addr), 0);
    chk("t6_wdata", bus.imem_wdata, 0);
    chk("t6_ready", 32'(bus.in_ready), 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(99) == 0, $urandom_range(99) < 5, $urandom_range(99) < 5,
           $urandom_range(99) < 75, $urandom_range(7), $urandom_range(31),
           $urandom_range(31), $urandom_range(31), $urandom_range(63), $urandom_range(65535));
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
